// File: rtl/noise_pkg.sv
// noise_pkg
//   Shared types and constants for the multi-channel noise source:
//   channel state encoding, LFSR seed and feedback taps, envelope ceiling,
//   and the LFSR next-state function used by the top-level generator.
package noise_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSTAIN = 2'd1,
    DECAY   = 2'd2
  } noise_state_e;

  localparam logic [15:0] LFSR_SEED = 16'h0001;
  localparam logic [15:0] ENV_MAX   = 16'hFFFF;

  localparam int LFSR_TAP_A = 15;
  localparam int LFSR_TAP_B = 13;
  localparam int LFSR_TAP_C = 12;
  localparam int LFSR_TAP_D = 10;

  // All-zero is a lock-up state for this XOR LFSR; recover to the seed.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic [15:0] nxt;
    if (cur == 16'h0000) begin
      nxt = LFSR_SEED;
    end else begin
      nxt = {cur[14:0],
             cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B] ^ cur[LFSR_TAP_C] ^ cur[LFSR_TAP_D]};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/noise_source_multi_if.sv
// noise_source_multi_if
//   Per-channel control and output bundle of the noise source.
//   noise_en   : per-channel trigger/sustain
//   loud_soft  : per-channel level select (1 = loud)
//   noise_out  : per-channel 16-bit sample, channel i at [16i+15:16i]
//   mix_out    : saturating sum of all channels
//   active     : per-channel "state is not IDLE"
//   master = sound controller, slave = noise source.
interface noise_source_multi_if #(
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0]    noise_en;
  logic [CHANNELS-1:0]    loud_soft;
  logic [16*CHANNELS-1:0] noise_out;
  logic [15:0]            mix_out;
  logic [CHANNELS-1:0]    active;

  modport master (
    output noise_en, loud_soft,
    input  noise_out, mix_out, active
  );

  modport slave (
    input  noise_en, loud_soft,
    output noise_out, mix_out, active
  );
endinterface

// File: rtl/noise_channel.sv
// noise_channel
//   One noise channel: IDLE/SUSTAIN/DECAY envelope FSM, registered sample.
//   Ports:
//     clk, reset          system clock, synchronous active-high reset
//     clk_3MHz_en         sample register strobe
//     clk_6KHz_en         decay strobe
//     sound_enable        global gate, forces IDLE when low
//     noise_en, loud_soft channel trigger and level select
//     lfsr                shared LFSR value (bit TAP is used)
//     sample_next         value the sample register loads on the next strobe
//     sample              registered channel output
//     active              state is not IDLE
//   Parameters: TAP (LFSR bit index), SHIFT (decay shift, 1..15).
module noise_channel
  import noise_pkg::*;
#(
  parameter logic [3:0] TAP   = 4'd4,
  parameter logic [3:0] SHIFT = 4'd6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_3MHz_en,
  input  logic        clk_6KHz_en,
  input  logic        sound_enable,
  input  logic        noise_en,
  input  logic        loud_soft,
  input  logic [15:0] lfsr,
  output logic [15:0] sample_next,
  output logic [15:0] sample,
  output logic        active
);

  noise_state_e state;
  logic [15:0]  env;
  logic [15:0]  decay_step;
  logic         noise_bit;

  assign noise_bit  = lfsr[TAP];
  assign decay_step = (env >> SHIFT) + 16'd1;
  assign active     = (state != IDLE);

  // Gating with sound_enable makes the output drop to 0 on the first
  // sample strobe after the gate falls, even if env has not cleared yet.
  always_comb begin
    sample_next = 16'h0000;
    if (sound_enable && noise_bit) begin
      sample_next = loud_soft ? env : (env >> 2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      env    <= 16'h0000;
      sample <= 16'h0000;
    end else begin
      if (clk_3MHz_en) begin
        sample <= sample_next;
      end
      if (!sound_enable) begin
        state <= IDLE;
        env   <= 16'h0000;
      end else begin
        case (state)
          IDLE: begin
            env <= 16'h0000;
            if (noise_en) begin
              state <= SUSTAIN;
              env   <= ENV_MAX;
            end
          end
          SUSTAIN: begin
            env <= ENV_MAX;
            if (!noise_en) begin
              state <= DECAY;
            end
          end
          DECAY: begin
            // Retrigger takes priority over a coincident decay strobe.
            if (noise_en) begin
              state <= SUSTAIN;
              env   <= ENV_MAX;
            end else if (clk_6KHz_en) begin
              if (env <= decay_step) begin
                env   <= 16'h0000;
                state <= IDLE;
              end else begin
                env <= env - decay_step;
              end
            end
          end
          default: begin
            state <= IDLE;
            env   <= 16'h0000;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    assert (SHIFT != 4'd0) else $error("noise_channel: SHIFT of 0 is illegal");
  end

endmodule

// File: rtl/noise_source_multi.sv
// noise_source_multi
//   Multi-channel noise generator: one shared 16-bit LFSR stepped on the
//   6 kHz strobe, CHANNELS envelope channels, saturating 16-bit mixer.
//   Ports:
//     clk, reset     system clock, synchronous active-high reset
//     clk_3MHz_en    output sample strobe
//     clk_6KHz_en    LFSR step and envelope decay strobe
//     sound_enable   global gate (freezes LFSR, idles channels)
//     bus            noise_source_multi_if slave (noise_en, loud_soft,
//                    noise_out, mix_out, active)
module noise_source_multi
  import noise_pkg::*;
#(
  parameter int                    CHANNELS    = 2,
  parameter logic [4*CHANNELS-1:0] TAP_SEL     = {4'd11, 4'd4},
  parameter logic [4*CHANNELS-1:0] DECAY_SHIFT = {4'd8, 4'd6}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_3MHz_en,
  input  logic                 clk_6KHz_en,
  input  logic                 sound_enable,
  noise_source_multi_if.slave  bus
);

  logic [15:0]            lfsr;
  logic [15:0]            samp_nxt [CHANNELS];
  logic [16*CHANNELS-1:0] samp_q;
  logic [CHANNELS-1:0]    act;
  logic [18:0]            acc;
  logic [15:0]            mix_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (clk_6KHz_en && sound_enable) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    noise_channel #(
      .TAP   (TAP_SEL[4*i +: 4]),
      .SHIFT (DECAY_SHIFT[4*i +: 4])
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .clk_3MHz_en  (clk_3MHz_en),
      .clk_6KHz_en  (clk_6KHz_en),
      .sound_enable (sound_enable),
      .noise_en     (bus.noise_en[i]),
      .loud_soft    (bus.loud_soft[i]),
      .lfsr         (lfsr),
      .sample_next  (samp_nxt[i]),
      .sample       (samp_q[16*i +: 16]),
      .active       (act[i])
    );
  end

  // Mixing the channels' next samples keeps mix_out aligned with noise_out:
  // both load on the same strobe from the same pre-edge env/lfsr.
  always_comb begin
    acc = 19'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      acc = acc + {3'b000, samp_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mix_q <= 16'h0000;
    end else if (clk_3MHz_en) begin
      mix_q <= (acc > 19'h0FFFF) ? ENV_MAX : acc[15:0];
    end
  end

  assign bus.noise_out = samp_q;
  assign bus.mix_out   = mix_q;
  assign bus.active    = act;

endmodule

// File: tb/tb_noise_source_multi.sv
module tb_noise_source_multi;

  logic clk          = 1'b0;
  logic reset        = 1'b1;
  logic clk_3MHz_en  = 1'b0;
  logic clk_6KHz_en  = 1'b0;
  logic sound_enable = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_lfsr;

  noise_source_multi_if #(.CHANNELS(2)) bus ();

  noise_source_multi #(
    .CHANNELS    (2),
    .TAP_SEL     ({4'd11, 4'd4}),
    .DECAY_SHIFT ({4'd8, 4'd6})
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_3MHz_en  (clk_3MHz_en),
    .clk_6KHz_en  (clk_6KHz_en),
    .sound_enable (sound_enable),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_shift(input logic [15:0] v);
    if (v == 16'h0000) return 16'h0001;
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] model_decay(input logic [15:0] e, input int sh);
    logic [16:0] d;
    d = {1'b0, (e >> sh)} + 17'd1;
    if (d >= {1'b0, e}) return 16'h0000;
    return e - d[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s6k();
    clk_6KHz_en = 1'b1;
    tick();
    clk_6KHz_en = 1'b0;
    if (sound_enable) m_lfsr = model_shift(m_lfsr);
  endtask

  task automatic s3m();
    clk_3MHz_en = 1'b1;
    tick();
    clk_3MHz_en = 1'b0;
  endtask

  initial begin
    logic [15:0] e;
    int bad;
    int steps;
    int n;
    int zero_seen;

    bus.noise_en  = 2'b00;
    bus.loud_soft = 2'b00;
    m_lfsr        = 16'h0001;

    repeat (3) tick();
    chk("rst_lfsr",      dut.lfsr,      32'h0001);
    chk("rst_active",    bus.active,    32'h0);
    chk("rst_noise_out", bus.noise_out, 32'h0);
    chk("rst_mix",       bus.mix_out,   32'h0);
    reset        = 1'b0;
    sound_enable = 1'b1;

    s6k();
    chk("lfsr_first_shift", dut.lfsr, 32'h0002);
    repeat (3) s6k();
    chk("lfsr_four_shifts", dut.lfsr, 32'h0010);

    // channel 0 sustain, tap bit 4 is 1 in 16'h0010
    bus.noise_en[0] = 1'b1;
    tick();
    chk("sus_active", bus.active, 32'h1);
    chk("sus_env",    dut.g_ch[0].u_ch.env, 32'hFFFF);
    bus.loud_soft[0] = 1'b0;
    s3m();
    chk("soft_out", bus.noise_out, 32'h0000_3FFF);
    chk("soft_mix", bus.mix_out,   32'h3FFF);
    bus.loud_soft[0] = 1'b1;
    s3m();
    chk("loud_out", bus.noise_out, 32'h0000_FFFF);

    // release and first decay step
    bus.noise_en[0] = 1'b0;
    tick();
    chk("rel_active", bus.active, 32'h1);
    chk("rel_env",    dut.g_ch[0].u_ch.env, 32'hFFFF);
    s6k();
    chk("decay1_env", dut.g_ch[0].u_ch.env, 32'hFBFF);

    e = 16'hFBFF; bad = 0; steps = 0;
    while (e != 16'h0000 && steps < 5000) begin
      s6k();
      e = model_decay(e, 6);
      steps++;
      if (dut.g_ch[0].u_ch.env !== e) bad++;
      if (bus.active[0] !== (e != 16'h0000)) bad++;
    end
    chk("decay_track", bad, 32'd0);
    chk("decay_idle",  bus.active, 32'h0);
    chk("lfsr_track1", dut.lfsr, m_lfsr);

    // retrigger from DECAY, coinciding with a decay strobe
    bus.noise_en[0] = 1'b1; tick();
    bus.noise_en[0] = 1'b0; tick();
    e = 16'hFFFF;
    repeat (5) begin s6k(); e = model_decay(e, 6); end
    chk("decay5_env", dut.g_ch[0].u_ch.env, e);
    bus.noise_en[0] = 1'b1;
    clk_6KHz_en = 1'b1;
    tick();
    clk_6KHz_en = 1'b0;
    m_lfsr = model_shift(m_lfsr);
    chk("retrig_env",    dut.g_ch[0].u_ch.env, 32'hFFFF);
    chk("retrig_active", bus.active, 32'h1);

    // bring both tap bits (4 and 11) high, then mix
    n = 0;
    while (!(m_lfsr[4] && m_lfsr[11]) && n < 70000) begin s6k(); n++; end
    chk("lfsr_search", dut.lfsr, m_lfsr);
    bus.noise_en  = 2'b11;
    bus.loud_soft = 2'b11;
    tick();
    s3m();
    chk("mix_sat_loud", bus.mix_out,   32'hFFFF);
    chk("out_loud2",    bus.noise_out, 32'hFFFF_FFFF);
    bus.loud_soft = 2'b00;
    s3m();
    chk("mix_soft2", bus.mix_out,   32'h7FFE);
    chk("out_soft2", bus.noise_out, 32'h3FFF_3FFF);
    bus.loud_soft = 2'b01;
    s3m();
    chk("mix_sat_mixed", bus.mix_out,   32'hFFFF);
    chk("out_mixed",     bus.noise_out, 32'h3FFF_FFFF);

    // sound_enable drops mid-decay
    bus.noise_en = 2'b00;
    tick();
    s6k();
    chk("pre_drop_active", bus.active, 32'h3);
    sound_enable = 1'b0;
    tick();
    chk("drop_active", bus.active, 32'h0);
    chk("drop_env0",   dut.g_ch[0].u_ch.env, 32'h0);
    s6k();
    chk("drop_lfsr_frozen", dut.lfsr, m_lfsr);
    s3m();
    chk("drop_out", bus.noise_out, 32'h0);
    chk("drop_mix", bus.mix_out,   32'h0);

    // reset mid-decay with strobes active
    sound_enable = 1'b1;
    bus.noise_en[0] = 1'b1; tick();
    bus.noise_en[0] = 1'b0; tick();
    s6k();
    chk("pre_rst_active", bus.active, 32'h1);
    reset = 1'b1; clk_6KHz_en = 1'b1; clk_3MHz_en = 1'b1;
    tick();
    reset = 1'b0; clk_6KHz_en = 1'b0; clk_3MHz_en = 1'b0;
    chk("mid_rst_lfsr",   dut.lfsr,   32'h0001);
    chk("mid_rst_active", bus.active, 32'h0);
    chk("mid_rst_env",    dut.g_ch[0].u_ch.env, 32'h0);
    chk("mid_rst_out",    bus.noise_out, 32'h0);
    m_lfsr = 16'h0001;

    // full period
    clk_6KHz_en = 1'b1;
    n = 0; zero_seen = 0;
    do begin
      tick();
      n++;
      if (dut.lfsr == 16'h0000) zero_seen++;
    end while (dut.lfsr != 16'h0001 && n < 70000);
    clk_6KHz_en = 1'b0;
    chk("lfsr_period", n, 32'd65535);
    chk("lfsr_no_zero", zero_seen, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
